// File: rtl/ntt_job_sched_if.sv
// ntt_job_sched_if: bundles the host command/response handshakes, the core
// controller start/mode/state wires, and the status outputs of the scheduler.
//   master : host/core side (drives commands, rsp_ready, core state)
//   slave  : scheduler side (ntt_job_sched)
// Signals:
//   cmd_valid/cmd_ready/cmd_mode[2:0]/cmd_tag[3:0]  command channel
//   flush                                           drop queued commands
//   rsp_valid/rsp_ready/rsp_tag[3:0]/rsp_err/rsp_cycles[15:0]  response channel
//   ntt_start/ntt_set_state[2:0]/ntt_cur_state[2:0] core controller link
//   busy/fifo_level[4:0]                            status
interface ntt_job_sched_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_mode;
  logic [3:0]  cmd_tag;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [15:0] rsp_cycles;
  logic        ntt_start;
  logic [2:0]  ntt_set_state;
  logic [2:0]  ntt_cur_state;
  logic        busy;
  logic [4:0]  fifo_level;

  modport master (
    output cmd_valid, cmd_mode, cmd_tag, flush, rsp_ready, ntt_cur_state,
    input  cmd_ready, rsp_valid, rsp_tag, rsp_err, rsp_cycles,
           ntt_start, ntt_set_state, busy, fifo_level
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_tag, flush, rsp_ready, ntt_cur_state,
    output cmd_ready, rsp_valid, rsp_tag, rsp_err, rsp_cycles,
           ntt_start, ntt_set_state, busy, fifo_level
  );
endinterface

// File: rtl/ntt_job_sched.sv
// ntt_job_sched: queues NTT/INTT job commands in a small FIFO, issues each
// job to the core controller as a one-cycle start pulse plus a held mode code,
// tracks completion from the core state and returns one in-order response per
// job with tag, error flag and a saturating cycle count.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (aborts any job, empties the FIFO)
//   bus  - ntt_job_sched_if.slave: command/response handshakes, flush,
//          core start/mode/state, busy and fifo_level status
// Parameters: DEPTH (FIFO depth, power of two 2..16), IDLE_CODE (core idle
//   encoding), TIMEOUT (watchdog limit in cycles from the start pulse).
// Build option: define NTT_SCHED_WDOG_EN to enable the completion watchdog.
module ntt_job_sched #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [2:0]  IDLE_CODE = 3'd0,
  parameter logic [15:0] TIMEOUT   = 16'd4000
) (
  input logic            clk,
  input logic            rst,
  ntt_job_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0] mode;
    logic [3:0] tag;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAITB, S_RUN, S_RESP} state_t;

  // ---------------- command FIFO ----------------
  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    level_q;
  logic          full, empty, push, pop;
  cmd_t          head;

  assign full  = (level_q == 5'(DEPTH));
  assign empty = (level_q == 5'd0);
  // Space is judged on the registered level, so a pop in the same cycle
  // never makes room for a push.
  assign bus.cmd_ready = !full && !bus.flush;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + 5'(push) - 5'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{mode: bus.cmd_mode, tag: bus.cmd_tag};
  end

  // ---------------- job FSM ----------------
  state_t      state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [3:0]  tag_q, tag_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] cnt_inc;
  logic        wdog_hit;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

`ifdef NTT_SCHED_WDOG_EN
  assign wdog_hit = (cnt_q == TIMEOUT);
`else
  logic unused_timeout;
  assign wdog_hit       = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= IDLE_CODE;
      tag_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !bus.flush) begin
          pop    = 1'b1;
          mode_d = head.mode;
          tag_d  = head.tag;
          // The idle code is not a runnable mode: answer with an error
          // straight away and never pulse the core.
          if (head.mode == IDLE_CODE) begin
            err_d   = 1'b1;
            cyc_d   = '0;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = 16'd1;
        state_d = S_WAITB;
      end
      S_WAITB: begin
        cnt_d = cnt_inc;
        if (bus.ntt_cur_state != IDLE_CODE) state_d = S_RUN;
        if (wdog_hit) begin
          err_d   = 1'b1;
          cyc_d   = TIMEOUT;
          state_d = S_RESP;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        // A genuine completion wins over a coincident watchdog expiry.
        if (bus.ntt_cur_state == IDLE_CODE) begin
          err_d   = 1'b0;
          cyc_d   = cnt_q;
          state_d = S_RESP;
        end else if (wdog_hit) begin
          err_d   = 1'b1;
          cyc_d   = TIMEOUT;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  assign bus.ntt_start     = (state_q == S_ISSUE);
  assign bus.ntt_set_state = (state_q == S_IDLE) ? IDLE_CODE : mode_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.rsp_valid     = (state_q == S_RESP);
  assign bus.rsp_tag       = tag_q;
  assign bus.rsp_err       = err_q;
  assign bus.rsp_cycles    = cyc_q;
  assign bus.fifo_level    = level_q;
endmodule

// File: tb/tb_ntt_job_sched.sv
// tb_ntt_job_sched: directed stimulus with a response scoreboard. Stimulus
// pushes hand-computed responses into a queue; a monitor pops and compares on
// every response handshake. A small core model goes busy the cycle after a
// start pulse for core_len cycles (or never, when core_hang is set).
module tb_ntt_job_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_job_sched_if bus();

  ntt_job_sched #(.DEPTH(4), .IDLE_CODE(3'd0), .TIMEOUT(16'd20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  tag;
    logic        err;
    logic [15:0] cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_start_tot = 0;
  int   core_len = 1;
  bit   core_hang = 1'b0;
  int   rem = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // core controller model
  always @(posedge clk) begin
    if (rst)                                rem <= 0;
    else if (bus.ntt_start && !core_hang)   rem <= core_len;
    else if (rem > 0)                       rem <= rem - 1;
  end
  assign bus.ntt_cur_state = (rem > 0) ? 3'd5 : 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic expect_rsp(input logic [3:0] tg, input logic e, input logic [15:0] c);
    exp_t x;
    x.tag = tg; x.err = e; x.cyc = c;
    sbq.push_back(x);
  endtask

  // monitor: samples just after the negedge, once all inputs have settled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && bus.ntt_start) n_start_tot++;
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL rsp_unexpected: got tag %0h err %0b cycles %0d, required no response",
                   bus.rsp_tag, bus.rsp_err, bus.rsp_cycles);
        end else begin
          e = sbq.pop_front();
          check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("rsp_cycles", 32'(bus.rsp_cycles), 32'(e.cyc));
        end
      end
    end
  end

  // called at a negedge; returns the cycle in which the handshake happened
  task automatic send(input logic [2:0] m, input logic [3:0] tg, output int t_acc);
    int k = 0;
    bus.cmd_mode = m; bus.cmd_tag = tg; bus.cmd_valid = 1'b1;
    #1;
    while (!bus.cmd_ready && k < 100) begin @(negedge clk); #1; k++; end
    if (k >= 100) bound_fail("send_accept");
    t_acc = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic v);
    int k = 0;
    while (bus.busy !== v && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) bound_fail("wait_busy");
  endtask

  task automatic drain();
    int k = 0;
    while ((sbq.size() != 0 || bus.busy) && k < 500) begin @(negedge clk); k++; end
    if (k >= 500) bound_fail("drain");
    repeat (3) @(negedge clk);
  endtask

  task automatic observe(input int t0, input int n, input logic [2:0] m,
                         output int st_n, output int st_at, output int rv_at, output int bad);
    st_n = 0; st_at = -1; rv_at = -1; bad = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (bus.ntt_start) begin st_n++; if (st_at < 0) st_at = cyc - t0; end
      if (bus.rsp_valid && rv_at < 0) rv_at = cyc - t0;
      if (bus.busy && bus.ntt_set_state !== m) bad++;
      if (!bus.busy && bus.ntt_set_state !== 3'd0) bad++;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t, h, st_n, st_at, rv_at, bad, acc, s0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_mode = '0; bus.cmd_tag = '0;
    bus.flush = 1'b0; bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    check("rst_ntt_start", 32'(bus.ntt_start), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rsp_tag_cycles", {12'd0, bus.rsp_tag, bus.rsp_cycles}, 0);
    check("rst_fifo_level", 32'(bus.fifo_level), 0);
    check("rst_set_state", 32'(bus.ntt_set_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // single job, core busy 10 cycles
    core_len = 10;
    expect_rsp(4'h5, 1'b0, 16'd11);
    send(3'd1, 4'h5, t);
    observe(t, 30, 3'd1, st_n, st_at, rv_at, bad);
    check("single_start_count", st_n, 1);
    check("single_start_at", st_at, 2);
    check("single_rsp_at", rv_at, 14);
    check("single_set_state", bad, 0);
    drain();

    // minimum latency, core busy 1 cycle
    core_len = 1;
    expect_rsp(4'h1, 1'b0, 16'd2);
    send(3'd2, 4'h1, t);
    observe(t, 12, 3'd2, st_n, st_at, rv_at, bad);
    check("lat_start_at", st_at, 2);
    check("lat_rsp_at", rv_at, 5);
    drain();

    // illegal mode
    expect_rsp(4'hA, 1'b1, 16'd0);
    send(3'd0, 4'hA, t);
    observe(t, 12, 3'd0, st_n, st_at, rv_at, bad);
    check("illegal_no_start", st_n, 0);
    check("illegal_rsp_at", rv_at, 2);
    drain();

    // fill while the head job keeps the core busy
    core_len = 15;
    expect_rsp(4'hE, 1'b0, 16'd16);
    send(3'd1, 4'hE, t);
    wait_busy(1'b1);
    for (int i = 0; i < 4; i++) begin
      expect_rsp(4'(i), 1'b0, 16'd4);
      send(3'd2, 4'(i), t);
    end
    core_len = 3;
    check("fill_level", 32'(bus.fifo_level), 4);
    check("fill_ready_low", 32'(bus.cmd_ready), 0);
    bus.cmd_mode = 3'd2; bus.cmd_tag = 4'h4; bus.cmd_valid = 1'b1;
    acc = 0;
    repeat (3) begin #1; if (bus.cmd_ready) acc++; @(negedge clk); end
    bus.cmd_valid = 1'b0;
    check("fill_no_accept", acc, 0);
    check("fill_level_held", 32'(bus.fifo_level), 4);
    drain();

    // flush while a job runs
    core_len = 12;
    expect_rsp(4'h7, 1'b0, 16'd13);
    send(3'd1, 4'h7, t);
    wait_busy(1'b1);
    send(3'd2, 4'h8, t);
    send(3'd2, 4'h9, t);
    send(3'd2, 4'hB, t);
    check("flush_pre_level", 32'(bus.fifo_level), 3);
    bus.flush = 1'b1;
    #1;
    check("flush_ready_low", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_level", 32'(bus.fifo_level), 0);
    drain();
    core_len = 2;
    expect_rsp(4'hC, 1'b0, 16'd3);
    send(3'd1, 4'hC, t);
    drain();

    // response backpressure
    bus.rsp_ready = 1'b0;
    core_len = 4;
    expect_rsp(4'h6, 1'b0, 16'd5);
    send(3'd3, 4'h6, t);
    expect_rsp(4'hD, 1'b0, 16'd5);
    send(3'd1, 4'hD, t);
    h = 0;
    while (!bus.rsp_valid && h < 100) begin @(negedge clk); h++; end
    if (h >= 100) bound_fail("bp_wait_valid");
    bad = 0;
    repeat (7) begin
      #1;
      if (!(bus.rsp_valid && bus.rsp_tag == 4'h6 && bus.rsp_cycles == 16'd5 && !bus.rsp_err)) bad++;
      @(negedge clk);
    end
    check("bp_hold", bad, 0);
    bus.rsp_ready = 1'b1;
    h = cyc;
    observe(h, 10, 3'd1, st_n, st_at, rv_at, bad);
    check("bp_next_start_at", st_at, 2);
    drain();

    // reset mid-job with queued commands
    core_len = 15;
    send(3'd1, 4'h1, t);
    wait_busy(1'b1);
    send(3'd2, 4'h2, t);
    send(3'd2, 4'h3, t);
    check("rstjob_level", 32'(bus.fifo_level), 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rstjob_busy", 32'(bus.busy), 0);
    check("rstjob_level0", 32'(bus.fifo_level), 0);
    check("rstjob_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rstjob_set_state", 32'(bus.ntt_set_state), 0);
    s0 = n_start_tot;
    repeat (20) @(negedge clk);
    check("rstjob_no_start", n_start_tot - s0, 0);

    // watchdog: core never leaves idle
    core_hang = 1'b1;
`ifdef NTT_SCHED_WDOG_EN
    expect_rsp(4'h3, 1'b1, 16'd20);
    send(3'd1, 4'h3, t);
    drain();
    check("wdog_idle", 32'(bus.busy), 0);
`else
    send(3'd1, 4'h3, t);
    repeat (60) @(negedge clk);
    check("nowdog_busy", 32'(bus.busy), 1);
    check("nowdog_no_rsp", 32'(bus.rsp_valid), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("nowdog_rst_busy", 32'(bus.busy), 0);
`endif
    core_hang = 1'b0;

    repeat (5) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ntt_job_sched.md
# ntt_job_sched

Command scheduler in front of the NTT core controller. Accepts NTT/INTT job commands from a host over a valid/ready interface and buffers them in a small FIFO. Issues each job to the core as a one-cycle start pulse plus a held mode code, then tracks completion from the core's state output. Returns one response per job with tag, error flag and measured cycle count.

## Interface
Parameters:
- DEPTH, 4: command FIFO depth; power of two, 2..16.
- IDLE_CODE, 3'd0: core state encoding meaning idle. Also the `ntt_set_state` value while no job is active.
- TIMEOUT, 16'd4000: watchdog limit in cycles, counted from the start pulse.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_mode  in  3  core mode code passed to `ntt_set_state`.
- cmd_tag  in  4  opaque job tag, echoed in the response.
- flush  in  1  discard all queued, not-yet-issued commands.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_tag  out  4  tag of the completed job.
- rsp_err  out  1  1 = illegal mode or watchdog timeout.
- rsp_cycles  out  16  cycles from the start pulse to completion; saturates at 16'hFFFF.
- ntt_start  out  1  one-cycle start pulse to the core controller.
- ntt_set_state  out  3  mode code to the core controller.
- ntt_cur_state  in  3  core controller's current state.
- busy  out  1  a job is in progress (FSM not in S_IDLE).
- fifo_level  out  5  number of queued commands.

## Operation
- FIFO stores {mode, tag}.
  - Enqueue on `cmd_valid & cmd_ready`.
  - `cmd_ready = !full & !flush`.
  - A same-cycle dequeue does not free space for an enqueue in that cycle.
- `flush`: clears the FIFO pointers and level in that cycle. Any in-flight job continues and still produces its response.
- FSM states: S_IDLE, S_ISSUE, S_WAITB, S_RUN, S_RESP.
  - S_IDLE: if the FIFO is non-empty and `flush` is low, pop the head into job registers.
    - Mode == IDLE_CODE: go to S_RESP with err=1, cycles=0, and no start pulse.
    - Otherwise: go to S_ISSUE.
  - S_ISSUE: `ntt_start`=1 for exactly this cycle. Cycle counter loads 1. Go to S_WAITB.
  - S_WAITB: on `ntt_cur_state != IDLE_CODE`, go to S_RUN.
  - S_RUN: on `ntt_cur_state == IDLE_CODE`, go to S_RESP with err=0.
  - S_RESP: hold `rsp_valid`, tag, err and cycles stable until `rsp_ready`, then go to S_IDLE.
- `ntt_set_state` = job mode from S_ISSUE through S_RESP. It equals IDLE_CODE in S_IDLE.
- Cycle counter increments in S_WAITB and S_RUN and saturates at all-ones. `rsp_cycles` = counter value on the completing cycle.

## Timing
- Reset values: `cmd_ready`=1 (DEPTH>0); `rsp_valid`, `rsp_err`, `ntt_start`, `busy`=0; `rsp_tag`, `rsp_cycles`, `fifo_level`=0; `ntt_set_state`=IDLE_CODE; FSM=S_IDLE.
- Reset mid-job: aborts immediately. FIFO emptied, no response produced. Driving the core back to idle is the core's own reset.
- Command accepted at cycle t into an empty FIFO with the FSM idle:
  - pop at t+1;
  - `ntt_start` high at t+2;
  - earliest `rsp_valid` at t+5 (core busy for 1 cycle).
- Back-to-back jobs: minimum 2 cycles from the response handshake to the next `ntt_start`.
- Responses are returned strictly in command order.

## Configuration
- Macro: `NTT_SCHED_WDOG_EN`.
- Defined: in S_WAITB/S_RUN, if the counter reaches TIMEOUT, go to S_RESP with err=1 and cycles=TIMEOUT. The next job waits as normal; the core is not reset by this block.
- Undefined: no watchdog. The FSM waits indefinitely for the core; err is set only for an illegal mode.

## Test plan
- Single job: mode 3'd1, tag 4'h5; model core busy for 10 cycles after start -> exactly one `ntt_start` pulse, `ntt_set_state`=1 during the job; response tag 5, err 0, cycles 11.
- Fill: 5 commands with no pops (core stalled) -> `cmd_ready` goes low after the 4th; `fifo_level`=4; tags returned in order 0,1,2,3 after release.
- Illegal mode: mode 3'd0, tag 4'hA -> no `ntt_start`; response err 1, cycles 0, tag A.
- Flush: queue 3 jobs while the first runs, assert `flush` one cycle -> only the first job responds; `fifo_level`=0; a later command is accepted normally.
- Watchdog (macro defined, TIMEOUT=20): core never leaves idle -> response err 1, cycles 20, FSM returns to S_IDLE. With the macro undefined -> no response, `busy` stays 1.
- Response backpressure: `rsp_ready` low for 7 cycles -> `rsp_valid`/tag/cycles held stable; next start occurs 2 cycles after the handshake.
